rv32i_core_top: RTL and testbench

- Top level of a minimal single-cycle RV32I processor with only a clock and a reset at its boundary.
- Contains the PC, the instruction memory, decode, a 32x32 register file, the ALU/branch unit and a data memory.
- Runs a preloaded program (riscv-tests style). Software signals completion through x26 and the pass/fail result through x27.
- The bench inspects internal state through fixed hierarchical names, listed under Behaviour.

---
 rtl/rv32i_core_top.sv | 273 +++++++++++++++++++++++++++
 tb/tb_rv32i_core_top.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_core_top.sv
//==============================================================================
// Module      : rv32i_core_top
// Description : Minimal single-cycle RV32I processor. Holds the PC,
//               the instruction memory, decode, the 32x32 register file,
//               the ALU/branch unit and a byte-writable data memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

//------------------------------------------------------------------------------
// Word-wide RAM: combinational read, synchronous per-byte write.
// Used for both instruction and data memory.
//------------------------------------------------------------------------------
module ram_gen #(
  parameter int DEPTH = 4096
) (
  input  wire         clk,
  input  wire  [29:0] i_word,
  input  wire  [3:0]  i_be,
  input  wire  [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  localparam int c_aw = $clog2(DEPTH);

  logic [31:0]     ram [0:DEPTH-1];
  logic [c_aw-1:0] w_idx;

  // Word index wraps modulo the memory depth.
  assign w_idx   = c_aw'(i_word % 30'(DEPTH));
  assign o_rdata = ram[w_idx];

  // Byte-lane write; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) ram[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end
endmodule

//------------------------------------------------------------------------------
// Instruction memory wrapper (read-only from the core's point of view).
//------------------------------------------------------------------------------
module inst_catch #(
  parameter int DEPTH = 4096
) (
  input  wire         clk,
  input  wire  [29:0] i_word,
  output logic [31:0] o_inst
);
  ram_gen #(.DEPTH(DEPTH)) u_ramGen (
    .clk     (clk),
    .i_word  (i_word),
    .i_be    (4'b0000),
    .i_wdata (32'h0000_0000),
    .o_rdata (o_inst)
  );
endmodule

//------------------------------------------------------------------------------
// 32x32 register file: two combinational reads, one synchronous write.
//------------------------------------------------------------------------------
module registers (
  input  wire         clk,
  input  wire         rst,
  input  wire  [4:0]  i_rs1,
  input  wire  [4:0]  i_rs2,
  input  wire  [4:0]  i_rd,
  input  wire         i_we,
  input  wire  [31:0] i_wdata,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data
);
  logic [31:0] regfile [0:31];

  // Reset clears every register; x0 is never written afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 32'h0;
    end else if (i_we && (i_rd != 5'd0)) begin
      regfile[i_rd] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1 == 5'd0) ? 32'h0 : regfile[i_rs1];
  assign o_rs2_data = (i_rs2 == 5'd0) ? 32'h0 : regfile[i_rs2];
endmodule

//------------------------------------------------------------------------------
// Core top level.
//------------------------------------------------------------------------------
module rv32i_core_top #(
  parameter int          IMEM_DEPTH = 4096,
  parameter int          DMEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input wire clk,
  input wire rst
);
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;

  logic [31:0] r_pc;
  logic [31:0] w_inst, w_pc_plus4, w_next_pc;
  logic [31:0] w_rs1_data, w_rs2_data;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_alu_b, w_alu_out;
  logic [31:0] w_mem_addr, w_mem_rdata, w_mem_wdata, w_load_data;
  logic [31:0] w_rd_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [3:0]  w_mem_be;
  logic        w_rd_we, w_taken, w_load_ok;

  inst_catch #(.DEPTH(IMEM_DEPTH)) u_InstCatch (
    .clk    (clk),
    .i_word (r_pc[31:2]),
    .o_inst (w_inst)
  );

  assign w_opcode   = w_inst[6:0];
  assign w_funct3   = w_inst[14:12];
  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_imm_i = {{21{w_inst[31]}}, w_inst[30:20]};
  assign w_imm_s = {{21{w_inst[31]}}, w_inst[30:25], w_inst[11:7]};
  assign w_imm_b = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'h000};
  assign w_imm_j = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  registers u_Registers (
    .clk        (clk),
    .rst        (rst),
    .i_rs1      (w_inst[19:15]),
    .i_rs2      (w_inst[24:20]),
    .i_rd       (w_inst[11:7]),
    .i_we       (w_rd_we),
    .i_wdata    (w_rd_data),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  // Stores are suppressed while reset is held so an aborted program leaves no partial write.
  ram_gen #(.DEPTH(DMEM_DEPTH)) u_DataMem (
    .clk     (clk),
    .i_word  (w_mem_addr[31:2]),
    .i_be    (rst ? 4'b0000 : w_mem_be),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign w_alu_b    = (w_opcode == c_op_reg) ? w_rs2_data : w_imm_i;
  assign w_mem_addr = w_rs1_data + ((w_opcode == c_op_store) ? w_imm_s : w_imm_i);

  // ALU shared by OP and OP-IMM; bit 30 selects SUB (register form only) and SRA.
  always_comb begin
    w_alu_out = 32'h0;
    case (w_funct3)
      3'b000: begin
        if ((w_opcode == c_op_reg) && w_inst[30]) w_alu_out = w_rs1_data - w_alu_b;
        else                                      w_alu_out = w_rs1_data + w_alu_b;
      end
      3'b001: w_alu_out = w_rs1_data << w_alu_b[4:0];
      3'b010: w_alu_out = {31'h0, $signed(w_rs1_data) < $signed(w_alu_b)};
      3'b011: w_alu_out = {31'h0, w_rs1_data < w_alu_b};
      3'b100: w_alu_out = w_rs1_data ^ w_alu_b;
      3'b101: begin
        if (w_inst[30]) w_alu_out = $signed(w_rs1_data) >>> w_alu_b[4:0];
        else            w_alu_out = w_rs1_data >> w_alu_b[4:0];
      end
      3'b110: w_alu_out = w_rs1_data | w_alu_b;
      default: w_alu_out = w_rs1_data & w_alu_b;
    endcase
  end

  // Branch condition; the two reserved funct3 codes never branch.
  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = (w_rs1_data == w_rs2_data);
      3'b001:  w_taken = (w_rs1_data != w_rs2_data);
      3'b100:  w_taken = ($signed(w_rs1_data) <  $signed(w_rs2_data));
      3'b101:  w_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      3'b110:  w_taken = (w_rs1_data <  w_rs2_data);
      3'b111:  w_taken = (w_rs1_data >= w_rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  // Load lane extraction and extension; unknown widths produce no writeback.
  always_comb begin
    w_ld_byte   = w_mem_rdata[{w_mem_addr[1:0], 3'b000} +: 8];
    w_ld_half   = w_mem_addr[1] ? w_mem_rdata[31:16] : w_mem_rdata[15:0];
    w_load_data = 32'h0;
    w_load_ok   = 1'b1;
    case (w_funct3)
      3'b000:  w_load_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b001:  w_load_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b010:  w_load_data = w_mem_rdata;
      3'b100:  w_load_data = {24'h0, w_ld_byte};
      3'b101:  w_load_data = {16'h0, w_ld_half};
      default: w_load_ok   = 1'b0;
    endcase
  end

  // Main decode: next PC, writeback and store lane enables.
  always_comb begin
    w_next_pc   = w_pc_plus4;
    w_rd_we     = 1'b0;
    w_rd_data   = w_alu_out;
    w_mem_be    = 4'b0000;
    w_mem_wdata = w_rs2_data;
    case (w_opcode)
      c_op_lui: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_imm_u;
      end
      c_op_auipc: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + w_imm_u;
      end
      c_op_jal: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      c_op_jalr: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = (w_rs1_data + w_imm_i) & ~32'd1;
      end
      c_op_branch: begin
        if (w_taken) w_next_pc = r_pc + w_imm_b;
      end
      c_op_load: begin
        w_rd_we   = w_load_ok;
        w_rd_data = w_load_data;
      end
      c_op_store: begin
        case (w_funct3)
          3'b000: begin
            w_mem_be    = 4'b0001 << w_mem_addr[1:0];
            w_mem_wdata = {4{w_rs2_data[7:0]}};
          end
          3'b001: begin
            w_mem_be    = w_mem_addr[1] ? 4'b1100 : 4'b0011;
            w_mem_wdata = {2{w_rs2_data[15:0]}};
          end
          3'b010:  w_mem_be = 4'b1111;
          default: w_mem_be = 4'b0000;
        endcase
      end
      c_op_imm, c_op_reg: w_rd_we = 1'b1;
      default: w_rd_we = 1'b0;
    endcase
  end

  // Program counter: one instruction retires per rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  end
endmodule

`default_nettype wire

// File: tb/tb_rv32i_core_top.sv
//==============================================================================
// Module      : tb_rv32i_core_top
// Description : Self-checking bench for rv32i_core_top: directed programs
//               with fixed expected values plus random programs compared
//               against an instruction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rv32i_core_top;
  localparam logic [31:0] c_loop = 32'h0000_006f;  // jal x0,0
  localparam logic [31:0] c_nop  = 32'h0000_0013;  // addi x0,x0,0

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] prog [$];
  logic [31:0] mreg [32];
  logic [31:0] mpc;
  logic [31:0] mmem [0:4095];

  rv32i_core_top #(
    .IMEM_DEPTH (4096),
    .DMEM_DEPTH (4096),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] rf(int i);
    return dut.u_Registers.regfile[i];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_i(logic [31:0] imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, int f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, int rs2, int rs1, int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm20, int rd, logic [6:0] op);
    return {imm20[19:0], 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6f};
  endfunction

  // Assert reset (async check before any edge), load program, hold 4 cycles, release.
  task automatic load_and_reset(string tag);
    logic [31:0] acc;
    @(negedge clk);
    rst = 1'b1;
    #1;
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    chk({tag, "_async_pc"}, dut.r_pc, 32'h0);
    chk({tag, "_async_regs"}, acc, 32'h0);
    for (int i = 0; i < 4096; i++)
      dut.u_InstCatch.u_ramGen.ram[i] <= (i < prog.size()) ? prog[i] : 32'h0;
    repeat (4) @(negedge clk);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    chk({tag, "_held_regs"}, acc, 32'h0);
    rst = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: one architectural instruction per call.
  task automatic model_step();
    logic [31:0] ins, a, b, ii, si, bi, ui, ji, res, npc, addr, w, mask, data;
    logic [4:0]  rd, sh;
    logic [2:0]  f3;
    logic        wr, tk;
    ins  = (int'(mpc >> 2) < prog.size()) ? prog[mpc >> 2] : 32'h0;
    rd   = ins[11:7];
    f3   = ins[14:12];
    a    = mreg[ins[19:15]];
    b    = mreg[ins[24:20]];
    ii   = {{20{ins[31]}}, ins[31:20]};
    si   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ui   = {ins[31:12], 12'h0};
    ji   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc  = mpc + 4;
    wr   = 1'b0;
    res  = 32'h0;
    case (ins[6:0])
      7'h37: begin wr = 1; res = ui; end
      7'h17: begin wr = 1; res = mpc + ui; end
      7'h6f: begin wr = 1; res = mpc + 4; npc = mpc + ji; end
      7'h67: begin wr = 1; res = mpc + 4; npc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = !($signed(a) < $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = !(a < b);
          default: tk = 0;
        endcase
        if (tk) npc = mpc + bi;
      end
      7'h03: begin
        addr = a + ii;
        w    = mmem[addr[13:2]];
        wr   = 1;
        case (f3)
          3'd0: begin res = (w >> (8 * addr[1:0])) & 32'hFF;   if (res[7])  res = res - 32'h100;   end
          3'd1: begin res = (w >> (16 * addr[1])) & 32'hFFFF; if (res[15]) res = res - 32'h10000; end
          3'd2: res = w;
          3'd4: res = (w >> (8 * addr[1:0])) & 32'hFF;
          3'd5: res = (w >> (16 * addr[1])) & 32'hFFFF;
          default: wr = 0;
        endcase
      end
      7'h23: begin
        addr = a + si;
        case (f3)
          3'd0: begin mask = 32'hFF << (8 * addr[1:0]);    data = b << (8 * addr[1:0]); end
          3'd1: begin mask = 32'hFFFF << (16 * addr[1]);   data = b << (16 * addr[1]);  end
          3'd2: begin mask = 32'hFFFF_FFFF;                 data = b;                    end
          default: begin mask = 32'h0; data = 32'h0; end
        endcase
        mmem[addr[13:2]] = (mmem[addr[13:2]] & ~mask) | (data & mask);
      end
      7'h13, 7'h33: begin
        if (ins[6:0] == 7'h33) ii = b;
        sh = ii[4:0];
        wr = 1;
        case (f3)
          3'd0: begin
            if (ins[6:0] == 7'h33 && ins[30]) res = a - ii;
            else                              res = a + ii;
          end
          3'd1: res = a << sh;
          3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: res = (a < ii) ? 32'd1 : 32'd0;
          3'd4: res = a ^ ii;
          3'd5: begin
            if (ins[30]) res = $signed(a) >>> sh;
            else         res = a >> sh;
          end
          3'd6: res = a | ii;
          default: res = a & ii;
        endcase
      end
      default: wr = 0;
    endcase
    if (wr && rd != 0) mreg[rd] = res;
    mpc = npc;
  endtask

  // Random program: zero a 64-byte data window, then a random mix, then a self-loop.
  task automatic gen_random(int n);
    prog.delete();
    for (int w = 0; w < 16; w++) prog.push_back(enc_s(32'h200 + 4 * w, 0, 0, 2));
    for (int k = 0; k < n; k++) begin
      int kind = $urandom_range(0, 9);
      int rd   = $urandom_range(0, 31);
      int r1   = $urandom_range(0, 31);
      int r2   = $urandom_range(0, 31);
      int f3   = $urandom_range(0, 7);
      int x;
      logic [31:0] imm;
      case (kind)
        0, 1, 2: begin
          if (f3 == 1)      imm = $urandom_range(0, 31);
          else if (f3 == 5) imm = $urandom_range(0, 31) | ($urandom_range(0, 1) ? 32'h400 : 32'h0);
          else              imm = $urandom_range(0, 4095);
          prog.push_back(enc_i(imm, r1, f3, rd, 7'h13));
        end
        3, 4: prog.push_back(enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                   r2, r1, f3, rd));
        5: prog.push_back(enc_u($urandom, rd, $urandom_range(0, 1) ? 7'h37 : 7'h17));
        6: prog.push_back(enc_s(32'h200 + $urandom_range(0, 63), r2, 0, $urandom_range(0, 2)));
        7: begin
          x = $urandom_range(0, 4);
          prog.push_back(enc_i(32'h200 + $urandom_range(0, 63), 0, (x < 3) ? x : x + 1, rd, 7'h03));
        end
        8: begin
          x = $urandom_range(0, 5);
          prog.push_back(enc_b($urandom_range(0, 1) ? 32'd8 : 32'd12, r2, r1, (x < 2) ? x : x + 2));
        end
        default: prog.push_back(enc_j(32'd8, rd));
      endcase
    end
    prog.push_back(c_nop);
    prog.push_back(c_nop);
    prog.push_back(c_loop);
  endtask

  // Small riscv-tests style image: test 1 checks add, test 2 checks sub.
  task automatic build_selftest(logic [31:0] expect2);
    prog = '{enc_i(1, 0, 0, 3, 7'h13), enc_i(3, 0, 0, 1, 7'h13), enc_i(4, 0, 0, 2, 7'h13),
             enc_r(7'h00, 2, 1, 0, 4), enc_i(7, 0, 0, 5, 7'h13), enc_b(32'h20, 5, 4, 1),
             enc_i(2, 0, 0, 3, 7'h13), enc_r(7'h20, 2, 1, 0, 4), enc_i(expect2, 0, 0, 5, 7'h13),
             enc_b(32'h10, 5, 4, 1), enc_i(1, 0, 0, 27, 7'h13), enc_i(1, 0, 0, 26, 7'h13), c_loop,
             enc_i(0, 0, 0, 27, 7'h13), enc_i(1, 0, 0, 26, 7'h13), c_loop};
  endtask

  task automatic wait_done(string tag);
    int cyc = 0;
    while (rf(26) !== 32'd1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_x26_done"}, rf(26), 32'd1);
  endtask

  initial begin
    // Reset then a single addi.
    prog = '{enc_i(5, 0, 0, 1, 7'h13), c_loop};
    load_and_reset("first");
    run(1);
    chk("addi_x1", rf(1), 32'd5);
    chk("addi_pc", dut.r_pc, 32'd4);

    // Shifts and unsigned compare.
    prog = '{enc_i(32'hFFF, 0, 0, 1, 7'h13), enc_i(28, 1, 5, 2, 7'h13),
             enc_i(32'h41C, 1, 5, 3, 7'h13), enc_r(7'h00, 1, 0, 3, 4), c_loop};
    load_and_reset("alu");
    run(4);
    chk("srli", rf(2), 32'h0000_000F);
    chk("srai", rf(3), 32'hFFFF_FFFF);
    chk("sltu", rf(4), 32'h0000_0001);

    // Writes to x0 are discarded.
    prog = '{enc_i(7, 0, 0, 0, 7'h13), enc_i(7, 0, 0, 5, 7'h13), c_loop};
    load_and_reset("x0");
    run(2);
    chk("x0_stays_zero", rf(0), 32'h0);
    chk("x5_after_x0", rf(5), 32'd7);

    // Loads and stores of every width.
    prog = '{enc_u(32'h80FF8, 1, 7'h37), enc_i(32'hF01, 1, 0, 1, 7'h13), enc_s(32'h100, 1, 0, 2),
             enc_i(32'h101, 0, 0, 2, 7'h03), enc_i(32'h103, 0, 4, 3, 7'h03),
             enc_i(32'h103, 0, 0, 4, 7'h03), enc_i(32'h102, 0, 5, 5, 7'h03),
             enc_i(32'h102, 0, 1, 6, 7'h03), enc_i(32'h100, 0, 2, 7, 7'h03),
             enc_s(32'h102, 1, 0, 0), enc_i(32'h100, 0, 2, 8, 7'h03),
             enc_s(32'h103, 1, 0, 1), enc_i(32'h100, 0, 2, 9, 7'h03), c_loop};
    load_and_reset("mem");
    run(13);
    chk("lb_101",  rf(2), 32'h0000_007F);
    chk("lbu_103", rf(3), 32'h0000_0080);
    chk("lb_103",  rf(4), 32'hFFFF_FF80);
    chk("lhu_102", rf(5), 32'h0000_80FF);
    chk("lh_102",  rf(6), 32'hFFFF_80FF);
    chk("lw_100",  rf(7), 32'h80FF_7F01);
    chk("sb_102",  rf(8), 32'h8001_7F01);
    chk("sh_103",  rf(9), 32'h7F01_7F01);

    // Branches, jal and jalr with rd == rs1 and an odd target.
    prog = '{enc_i(1, 0, 0, 1, 7'h13), enc_b(8, 1, 1, 1), enc_i(2, 0, 0, 2, 7'h13),
             enc_b(8, 0, 0, 0), enc_i(3, 0, 0, 3, 7'h13), enc_i(4, 0, 0, 4, 7'h13),
             c_nop, c_nop, enc_j(8, 1), enc_i(5, 0, 0, 5, 7'h13), enc_i(32'h41, 0, 0, 6, 7'h13),
             enc_i(0, 6, 0, 6, 7'h67), enc_i(9, 0, 0, 9, 7'h13), enc_i(9, 0, 0, 9, 7'h13),
             enc_i(9, 0, 0, 9, 7'h13), enc_i(9, 0, 0, 9, 7'h13), enc_i(8, 0, 0, 8, 7'h13), c_loop};
    load_and_reset("ctl");
    run(8);
    chk("jal_link", rf(1), 32'h24);
    chk("jal_pc",   dut.r_pc, 32'h28);
    run(5);
    chk("bne_nt_fallthru", rf(2), 32'd2);
    chk("beq_t_skipped",   rf(3), 32'd0);
    chk("beq_t_target",    rf(4), 32'd4);
    chk("jal_skipped",     rf(5), 32'd0);
    chk("jalr_link",       rf(6), 32'h30);
    chk("jalr_skipped",    rf(9), 32'd0);
    chk("jalr_target",     rf(8), 32'd8);
    chk("jalr_loop_pc",    dut.r_pc, 32'h44);

    // Self-test image, aborted part-way by reset, then run to completion.
    build_selftest(32'hFFF);
    load_and_reset("pass_a");
    run(6);
    load_and_reset("pass_abort");
    wait_done("pass");
    chk("pass_x27", rf(27), 32'd1);
    chk("pass_x3",  rf(3),  32'd2);

    // Deliberately failing image: test 2 expects the wrong difference.
    build_selftest(32'hFFE);
    load_and_reset("fail");
    wait_done("fail");
    chk("fail_x27", rf(27), 32'd0);
    chk("fail_x3",  rf(3),  32'd2);

    // Random programs against the reference model.
    for (int p = 0; p < 4; p++) begin
      int n;
      gen_random(40);
      n = prog.size() + 10;
      load_and_reset($sformatf("rnd%0d", p));
      run(n);
      mpc = 32'h0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      repeat (n) model_step();
      for (int i = 0; i < 32; i++) chk($sformatf("rnd%0d_x%0d", p, i), rf(i), mreg[i]);
      chk($sformatf("rnd%0d_pc", p), dut.r_pc, mpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
